// File: rtl/mem_bus_master_pkg.sv
// Shared widths, memory enable encodings and FSM states for the data-memory bus master.
package mem_bus_master_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    localparam logic [1:0] MEM_EN_ON  = 2'b01;
    localparam logic [1:0] MEM_EN_OFF = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VRD   = 3'd3,
        ST_VCMP  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_bus_master.sv
// Initiator for the 32x8 data memory: one request at a time, registered outputs, one response per request.
// Optional write read-back verification is enabled with MEM_BUS_MASTER_WR_VERIFY_EN.
module mem_bus_master
    import mem_bus_master_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_we,
    output logic [1:0]        mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state;
    logic   is_write;

    // mem_addr and mem_wdata double as the latched request, so they hold while idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            is_write   <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= MEM_EN_OFF;
            mem_re     <= MEM_EN_OFF;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_write  <= req_write;
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                        mem_we    <= req_write ? MEM_EN_ON : MEM_EN_OFF;
                        mem_re    <= req_write ? MEM_EN_OFF : MEM_EN_ON;
                        req_ready <= 1'b0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_we <= MEM_EN_OFF;
                    mem_re <= MEM_EN_OFF;
                    if (is_write) begin
`ifdef MEM_BUS_MASTER_WR_VERIFY_EN
                        mem_re <= MEM_EN_ON;
                        state  <= ST_VRD;
`else
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
`endif
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    resp_rdata <= mem_rdata;
                    resp_valid <= 1'b1;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
`ifdef MEM_BUS_MASTER_WR_VERIFY_EN
                ST_VRD: begin
                    mem_re <= MEM_EN_OFF;
                    state  <= ST_VCMP;
                end
                // Read-back is compared against the data the write actually drove.
                ST_VCMP: begin
                    resp_rdata <= mem_rdata;
                    resp_err   <= (mem_rdata != mem_wdata);
                    resp_valid <= 1'b1;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
`endif
                default: begin
                    mem_we    <= MEM_EN_OFF;
                    mem_re    <= MEM_EN_OFF;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: behavioural 32x8 memory, transaction-level reference model, directed and random stimulus.
module tb_mem_bus_master;
    import mem_bus_master_pkg::*;

`ifdef MEM_BUS_MASTER_WR_VERIFY_EN
    localparam bit VERIFY = 1'b1;
    localparam int WLAT   = 4;
`else
    localparam bit VERIFY = 1'b0;
    localparam int WLAT   = 2;
`endif

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_we;
    logic [1:0]        mem_re;
    logic [DATA_W-1:0] mem_rdata = '0;

    int  tests = 0;
    int  fails = 0;
    bit  force_zero = 1'b0;

    mem_bus_master dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Memory cells start from a known pattern so reads of untouched cells are checkable.
    logic [7:0] mem [32];
    bit         mem_init = 1'b0;
    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 3);
            mem_init = 1'b1;
        end
        if (mem_we == 2'b01)
            mem[mem_addr] = force_zero ? 8'h00 : mem_wdata;
        else if (mem_re == 2'b01)
            mem_rdata <= mem[mem_addr];
    end

    // Reference model: per-transaction phase count, latency from the request type, shadow memory contents.
    logic [7:0] shadow [32];
    bit         shadow_init = 1'b0;
    int         ph = 0;
    int         lat = 0;
    logic       op_w = 1'b0;
    logic [4:0] op_a = '0;
    logic [7:0] op_d = '0;
    logic       e_ready = 1'b1, e_rv = 1'b0, e_err = 1'b0, e_we = 1'b0, e_re = 1'b0;
    logic [7:0] e_rdata = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!shadow_init) begin
            for (int i = 0; i < 32; i++) shadow[i] = 8'(i * 7 + 3);
            shadow_init = 1'b1;
        end
        if (!reset_n) begin
            ph = 0; e_ready = 1'b1; e_rv = 1'b0; e_err = 1'b0;
            e_we = 1'b0; e_re = 1'b0; e_rdata = '0;
        end else begin
            e_rv = 1'b0; e_err = 1'b0; e_we = 1'b0; e_re = 1'b0;
            if (ph == 0) begin
                if (req_valid) begin
                    op_w = req_write; op_a = req_addr; op_d = req_wdata;
                    lat = op_w ? WLAT : 3;
                    ph = 1;
                    e_ready = 1'b0;
                    if (op_w) begin
                        shadow[op_a] = force_zero ? 8'h00 : op_d;
                        e_we = 1'b1;
                    end else begin
                        e_re = 1'b1;
                    end
                end
            end else begin
                ph = ph + 1;
                if (VERIFY && op_w && ph == 2) e_re = 1'b1;
                if (ph == lat) begin
                    ph = 0;
                    e_ready = 1'b1;
                    e_rv = 1'b1;
                    e_rdata = (op_w && !VERIFY) ? 8'h00 : shadow[op_a];
                    e_err = VERIFY && op_w && (shadow[op_a] != op_d);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle out of reset the DUT outputs must match the model.
    always @(negedge clock) begin
        if (reset_n) begin
            checkOutput("req_ready", 32'(req_ready), 32'(e_ready));
            checkOutput("resp_valid", 32'(resp_valid), 32'(e_rv));
            checkOutput("resp_err", 32'(resp_err), 32'(e_err));
            checkOutput("mem_we", 32'(mem_we), e_we ? 32'd1 : 32'd0);
            checkOutput("mem_re", 32'(mem_re), e_re ? 32'd1 : 32'd0);
            if (e_we || e_re) checkOutput("mem_addr", 32'(mem_addr), 32'(op_a));
            if (e_we) checkOutput("mem_wdata", 32'(mem_wdata), 32'(op_d));
            if (e_rv) checkOutput("resp_rdata", 32'(resp_rdata), 32'(e_rdata));
        end
    end

    task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [7:0] d, input bit keep);
        bit got = 1'b0;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #2;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic waitResp(output int n, output logic [7:0] d, output logic e);
        n = 0; d = '0; e = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (resp_valid) begin
                n = i; d = resp_rdata; e = resp_err;
                break;
            end
        end
        if (n == 0) checkOutput("resp_timeout", 32'd0, 32'd1);
    endtask

    int         n;
    logic [7:0] d;
    logic       e;

    initial begin
        #1;
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_re", 32'(mem_re), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        #21 reset_n = 1'b1;
        @(negedge clock);
        checkOutput("ready_after_reset", 32'(req_ready), 32'd1);

        $display("[TB] write then read at cell 3");
        applyStimulus(1'b1, 5'd3, 8'hA5, 1'b0);
        waitResp(n, d, e);
        checkOutput("wr_latency", 32'(n), 32'(WLAT));
        checkOutput("wr_err", 32'(e), 32'd0);
        checkOutput("wr_rdata", 32'(d), VERIFY ? 32'hA5 : 32'h00);
        applyStimulus(1'b0, 5'd3, 8'h00, 1'b0);
        waitResp(n, d, e);
        checkOutput("rd_latency", 32'(n), 32'd3);
        checkOutput("rd_data_3", 32'(d), 32'hA5);

        $display("[TB] back-to-back alternating requests at cell 31");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i[0] == 1'b0, 5'd31, 8'h3C, 1'b1);
            waitResp(n, d, e);
            if (i[0]) checkOutput("b2b_rd_data", 32'(d), 32'h3C);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clock);

        $display("[TB] reset during read wait state");
        applyStimulus(1'b1, 5'd7, 8'h77, 1'b0);
        waitResp(n, d, e);
        applyStimulus(1'b0, 5'd7, 8'h00, 1'b0);
        @(negedge clock);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midrst_mem_re", 32'(mem_re), 32'd0);
        checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("no_resp_after_rst", 32'(resp_valid), 32'd0);
        end
        applyStimulus(1'b0, 5'd7, 8'h00, 1'b0);
        waitResp(n, d, e);
        checkOutput("rd_after_rst_lat", 32'(n), 32'd3);
        checkOutput("rd_after_rst_data", 32'(d), 32'h77);

        $display("[TB] request withdrawn before acceptance");
        applyStimulus(1'b0, 5'd3, 8'h00, 1'b0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd9; req_wdata = 8'hEE;
        @(posedge clock);
        #2 req_valid = 1'b0;
        waitResp(n, d, e);
        @(posedge clock);
        #2 req_valid = 1'b1;
        #2 req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("withdrawn_we", 32'(mem_we), 32'd0);
            checkOutput("withdrawn_re", 32'(mem_re), 32'd0);
        end
        applyStimulus(1'b0, 5'd9, 8'h00, 1'b0);
        waitResp(n, d, e);
        checkOutput("cell9_untouched", 32'(d), 32'(8'd66));

`ifdef MEM_BUS_MASTER_WR_VERIFY_EN
        $display("[TB] write verify with corrupted and clean memory");
        force_zero = 1'b1;
        applyStimulus(1'b1, 5'd10, 8'h5A, 1'b0);
        waitResp(n, d, e);
        checkOutput("vfy_bad_lat", 32'(n), 32'd4);
        checkOutput("vfy_bad_err", 32'(e), 32'd1);
        checkOutput("vfy_bad_rdata", 32'(d), 32'h00);
        @(posedge clock);
        #2 force_zero = 1'b0;
        applyStimulus(1'b1, 5'd10, 8'h5A, 1'b0);
        waitResp(n, d, e);
        checkOutput("vfy_ok_err", 32'(e), 32'd0);
        checkOutput("vfy_ok_rdata", 32'(d), 32'h5A);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #2;
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 5'($urandom_range(0, 7));
            req_wdata = 8'($urandom);
        end
        req_valid = 1'b0;
        repeat (8) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
